// File: rtl/sar_adc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sar_adc_pkg                                                                |
// | Shared state encoding and default sizing for the SAR ADC controller.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    BIT    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int c_def_n_bits        = 8;
  localparam int c_def_sample_cycles = 4;
  localparam int c_def_settle_cycles = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rise_detect                                                                |
// | Registered-history rising-edge detector; one-cycle strobe on 0->1.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic r_level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= level;
    end
  end

  assign rise = level & ~r_level_q;

endmodule
`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sar_adc_ctrl                                                               |
// | SAR conversion sequencer: track/hold, binary search on the DAC trial code, |
// | result delivery on valid/ready with a sticky overrun flag.                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int N_BITS        = c_def_n_bits,
  parameter int SAMPLE_CYCLES = c_def_sample_cycles,
  parameter int SETTLE_CYCLES = c_def_settle_cycles
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_clk,
  input  logic              enable,
  input  logic              comp_in,
  output logic [N_BITS-1:0] dac_code,
  output logic              sample_hold,
  output logic              busy,
  output logic [N_BITS-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int c_ph_max = max_int(SAMPLE_CYCLES, SETTLE_CYCLES + 1);
  localparam int c_ph_w   = $clog2(c_ph_max + 1);
  localparam int c_bit_w  = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [c_ph_w-1:0]  c_sample_last = c_ph_w'(SAMPLE_CYCLES - 1);
  localparam logic [c_ph_w-1:0]  c_settle_last = c_ph_w'(SETTLE_CYCLES);
  localparam logic [c_bit_w-1:0] c_bit_top     = c_bit_w'(N_BITS - 1);
  localparam logic [N_BITS-1:0]  c_msb         = N_BITS'(1) << (N_BITS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [c_ph_w-1:0]   r_phase;
  logic [c_bit_w-1:0]  r_bit_idx;
  logic [N_BITS-1:0]   r_code;
  logic [N_BITS-1:0]   r_result;
  logic                r_valid;
  logic                r_overrun;

  logic                w_trigger;
  logic                w_busy;
  logic                w_sample_hold;
  logic                w_phase_last;
  logic                w_complete;
  logic                w_abort;
  logic                w_overrun_set;
  logic [N_BITS-1:0]   w_trial;
  logic [N_BITS-1:0]   w_decided;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .level (sample_clk),
    .rise  (w_trigger)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_busy        = 1'b0;
    w_sample_hold = 1'b0;
    w_phase_last  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trigger && enable) w_state_next = SAMPLE;
      end
      SAMPLE: begin
        w_busy        = 1'b1;
        w_sample_hold = 1'b1;
        w_phase_last  = (r_phase == c_sample_last);
        if (!enable)           w_state_next = IDLE;
        else if (w_phase_last) w_state_next = BIT;
      end
      BIT: begin
        w_busy       = 1'b1;
        w_phase_last = (r_phase == c_settle_last);
        if (!enable)                                w_state_next = IDLE;
        else if (w_phase_last && r_bit_idx == '0)   w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Trial bit is kept only if the comparator says Vin is at or above the trial level.
  assign w_trial       = N_BITS'(1) << r_bit_idx;
  assign w_decided     = comp_in ? r_code : (r_code & ~w_trial);
  assign w_abort       = w_busy && !enable;
  assign w_complete    = (r_state == BIT) && enable && w_phase_last && (r_bit_idx == '0);
  assign w_overrun_set = (w_complete && r_valid && !result_ready) ||
                         (w_trigger && enable && (r_state != IDLE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase   <= '0;
      r_bit_idx <= '0;
      r_code    <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if ((w_state_next != r_state) || w_phase_last) begin
        r_phase <= '0;
      end else if (w_busy) begin
        r_phase <= r_phase + c_ph_w'(1);
      end

      case (r_state)
        SAMPLE: begin
          if (enable && w_phase_last) begin
            r_code    <= c_msb;
            r_bit_idx <= c_bit_top;
          end
        end
        BIT: begin
          if (enable && w_phase_last) begin
            if (r_bit_idx == '0) begin
              r_code <= '0;
            end else begin
              r_code    <= w_decided | (w_trial >> 1);
              r_bit_idx <= r_bit_idx - c_bit_w'(1);
            end
          end
        end
        default: begin
          r_code <= '0;
        end
      endcase
      if (w_abort) r_code <= '0;

      // A completion loads the new code even if the old one is still pending.
      if (w_complete) begin
        r_result <= w_decided;
        r_valid  <= 1'b1;
      end else if (r_valid && result_ready) begin
        r_valid <= 1'b0;
      end

      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign dac_code     = r_code;
  assign sample_hold  = w_sample_hold;
  assign busy         = w_busy;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sar_adc_ctrl                                                            |
// | Directed bench for sar_adc_ctrl with an ideal comparator and divided clock.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_clk;
  logic       enable;
  logic       comp_in;
  logic [7:0] dac_code;
  logic       sample_hold;
  logic       busy;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       overrun;
  logic       overrun_clr;

  logic [7:0] vin;
  int         total = 0;
  int         bad = 0;
  int         half = 32;
  int         div_cnt;
  bit         div_en = 1'b0;

  always #5 clk = ~clk;

  assign comp_in = (vin >= dac_code);

  sar_adc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .sample_clk   (sample_clk),
    .enable       (enable),
    .comp_in      (comp_in),
    .dac_code     (dac_code),
    .sample_hold  (sample_hold),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  // Divided clock: toggles every 'half' clk cycles, restarted low while div_en=0.
  initial begin
    sample_clk = 1'b0;
    div_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!div_en) begin
        sample_clk = 1'b0;
        div_cnt    = 0;
      end else begin
        div_cnt++;
        if (div_cnt >= half) begin
          div_cnt    = 0;
          sample_clk = ~sample_clk;
        end
      end
    end
  end

  task automatic do_reset(input int hp);
    @(negedge clk);
    reset = 1'b1; div_en = 1'b0; half = hp;
    enable = 1'b1; result_ready = 1'b1; overrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; div_en = 1'b1;
  endtask

  // Returns at the falling edge inside trigger cycle T.
  task automatic wait_trigger();
    logic prev;
    bit   found;
    found = 1'b0;
    @(negedge clk);
    prev = sample_clk;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sample_clk && !prev) begin
        found = 1'b1;
        break;
      end
      prev = sample_clk;
    end
    total++;
    if (!found) begin bad++; $display("FAIL trigger_timeout: got no rise want rise within 200 cycles"); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; vin = 8'hA5; enable = 1'b1; result_ready = 1'b0; overrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (dac_code !== 8'h00) begin bad++; $display("FAIL reset_dac: got %h want 00", dac_code); end
    total++; if (sample_hold !== 1'b0) begin bad++; $display("FAIL reset_sh: got %b want 0", sample_hold); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", result); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_basic();
    do_reset(32);
    vin = 8'hA5;
    wait_trigger();
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      total++; if (sample_hold !== 1'(k <= 4)) begin bad++; $display("FAIL basic_sh k=%0d: got %b want %b", k, sample_hold, k <= 4); end
      total++; if (busy !== 1'(k <= 28)) begin bad++; $display("FAIL basic_busy k=%0d: got %b want %b", k, busy, k <= 28); end
      total++; if (result_valid !== 1'(k == 29)) begin bad++; $display("FAIL basic_valid k=%0d: got %b want %b", k, result_valid, k == 29); end
      if (k == 29) begin
        total++; if (result !== 8'hA5) begin bad++; $display("FAIL basic_result: got %h want a5", result); end
      end
    end
  endtask

  task automatic test_extremes();
    logic [7:0] seq [2][8];
    logic [7:0] exp_dac;
    seq = '{'{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01},
            '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF}};
    do_reset(32);
    for (int t = 0; t < 2; t++) begin
      vin = (t == 0) ? 8'h00 : 8'hFF;
      wait_trigger();
      for (int k = 1; k <= 29; k++) begin
        @(negedge clk);
        if (k >= 5 && k <= 28) exp_dac = seq[t][(k - 5) / 3];
        else                   exp_dac = 8'h00;
        total++; if (dac_code !== exp_dac) begin bad++; $display("FAIL extreme_dac vin=%h k=%0d: got %h want %h", vin, k, dac_code, exp_dac); end
        if (k == 29) begin
          total++; if (result !== vin) begin bad++; $display("FAIL extreme_result: got %h want %h", result, vin); end
          total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL extreme_valid: got %b want 1", result_valid); end
        end
      end
    end
  endtask

  task automatic test_overrun();
    do_reset(32);
    result_ready = 1'b0; vin = 8'h10;
    wait_trigger();
    repeat (29) @(negedge clk);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid1: got %b want 1", result_valid); end
    total++; if (result !== 8'h10) begin bad++; $display("FAIL ovr_result1: got %h want 10", result); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_flag1: got %b want 0", overrun); end
    vin = 8'h20;
    wait_trigger();
    repeat (28) @(negedge clk);
    total++; if (result !== 8'h10) begin bad++; $display("FAIL ovr_held: got %h want 10", result); end
    @(negedge clk);
    total++; if (result !== 8'h20) begin bad++; $display("FAIL ovr_result2: got %h want 20", result); end
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid2: got %b want 1", result_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag2: got %b want 1", overrun); end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr: got %b want 0", overrun); end
    result_ready = 1'b1;
    @(negedge clk);
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: got %b want 0", result_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset(10);
    vin = 8'h3C;
    wait_trigger();
    for (int k = 1; k <= 69; k++) begin
      @(negedge clk);
      if (k == 19) begin
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_pre: got %b want 0", overrun); end
      end
      if (k == 20) overrun_clr = 1'b1;
      if (k == 21) begin
        overrun_clr = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy); end
      end
      if (k == 29 || k == 69) begin
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid k=%0d: got %b want 1", k, result_valid); end
        total++; if (result !== 8'h3C) begin bad++; $display("FAIL b2b_result k=%0d: got %h want 3c", k, result); end
      end
      if (k == 30) begin
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL b2b_drop: got %b want 0", result_valid); end
      end
      if (k == 41) begin
        total++; if (sample_hold !== 1'b1) begin bad++; $display("FAIL b2b_restart: got %b want 1", sample_hold); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(32);
    result_ready = 1'b0; vin = 8'h11;
    wait_trigger();
    repeat (29) @(negedge clk);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL rmid_pending: got %b want 1", result_valid); end
    wait_trigger();
    repeat (12) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy0: got %b want 0", busy); end
    total++; if (dac_code !== 8'h00) begin bad++; $display("FAIL rmid_dac: got %h want 00", dac_code); end
    total++; if (sample_hold !== 1'b0) begin bad++; $display("FAIL rmid_sh: got %b want 0", sample_hold); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", result_valid); end
    total++; if (result !== 8'h00) begin bad++; $display("FAIL rmid_result: got %h want 00", result); end
    for (int i = 0; i < 100; i++) begin
      if (!sample_clk) break;
      @(negedge clk);
    end
    reset = 1'b0; vin = 8'h5A; result_ready = 1'b1;
    wait_trigger();
    repeat (29) @(negedge clk);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL rmid_valid2: got %b want 1", result_valid); end
    total++; if (result !== 8'h5A) begin bad++; $display("FAIL rmid_result2: got %h want 5a", result); end
  endtask

  task automatic test_enable_abort();
    do_reset(32);
    result_ready = 1'b0; vin = 8'h77;
    wait_trigger();
    repeat (29) @(negedge clk);
    total++; if (result !== 8'h77) begin bad++; $display("FAIL abort_first: got %h want 77", result); end
    wait_trigger();
    repeat (8) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b want 1", busy); end
    enable = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy0: got %b want 0", busy); end
    total++; if (dac_code !== 8'h00) begin bad++; $display("FAIL abort_dac: got %h want 00", dac_code); end
    total++; if (sample_hold !== 1'b0) begin bad++; $display("FAIL abort_sh: got %b want 0", sample_hold); end
    repeat (25) @(negedge clk);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL abort_pending: got %b want 1", result_valid); end
    total++; if (result !== 8'h77) begin bad++; $display("FAIL abort_untouched: got %h want 77", result); end
    wait_trigger();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL disabled_trig: got %b want 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL disabled_ovr: got %b want 0", overrun); end
    result_ready = 1'b1;
    @(negedge clk);
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL abort_drain: got %b want 0", result_valid); end
    enable = 1'b1; vin = 8'hC3;
    wait_trigger();
    repeat (29) @(negedge clk);
    total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL abort_valid2: got %b want 1", result_valid); end
    total++; if (result !== 8'hC3) begin bad++; $display("FAIL abort_result2: got %h want c3", result); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; result_ready = 1'b0; overrun_clr = 1'b0; vin = 8'h00;
    test_reset();
    test_basic();
    test_extremes();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_enable_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
